// File: rtl/bus_poll_scheduler_if.sv
// Request/response channel between the poll scheduler and master_device.
// The scheduler drives requests and receives one response byte per request.
interface bus_poll_scheduler_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/bus_poll_scheduler.sv
// Round-robin poll sequencer: sweeps a table of slave addresses, issues one read per
// enabled slot, stores each response byte and flags slots that never answer.
module bus_poll_scheduler #(
    parameter  int unsigned N_SLOTS = 4,
    parameter  int unsigned ADDR_W  = 8,
    parameter  int unsigned DATA_W  = 8,
    parameter  int unsigned TIMEOUT = 64,
    parameter  int unsigned GAP     = 16,
    localparam int unsigned IW      = $clog2(N_SLOTS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_cfg_we,
    input  logic [IW-1:0]      i_cfg_idx,
    input  logic [ADDR_W-1:0]  i_cfg_addr,
    input  logic               i_cfg_on,
    input  logic [IW-1:0]      i_rd_idx,
    output logic [DATA_W-1:0]  o_rd_data,
    output logic               o_rd_fresh,
    output logic [N_SLOTS-1:0] o_to_flags,
    output logic               o_sweep_done,
    output logic               o_busy,
    bus_poll_scheduler_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    state_t              r_state;
    logic [IW-1:0]       r_ptr;
    logic [ADDR_W-1:0]   r_addr   [N_SLOTS];
    logic [DATA_W-1:0]   r_result [N_SLOTS];
    logic [N_SLOTS-1:0]  r_on;
    logic [N_SLOTS-1:0]  r_fresh;
    logic [N_SLOTS-1:0]  r_to;
    logic [TW-1:0]       r_timer;
    logic [GW-1:0]       r_gap_cnt;
    logic                r_req_valid;
    logic [ADDR_W-1:0]   r_req_addr;
    logic                r_sweep_done;

    logic                w_any_on;
    logic [IW-1:0]       w_first_ge;
    logic [IW-1:0]       w_next;

    // Slot search: first enabled at/after ptr (IDLE start) and strictly after ptr (advance).
    always_comb begin
        w_any_on   = |r_on;
        w_first_ge = r_ptr;
        w_next     = r_ptr;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (r_on[r_ptr + IW'(i)]) w_first_ge = r_ptr + IW'(i);
        end
        for (int i = N_SLOTS; i >= 1; i--) begin
            if (r_on[r_ptr + IW'(i)]) w_next = r_ptr + IW'(i);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_on         <= '0;
            r_fresh      <= '0;
            r_to         <= '0;
            r_timer      <= '0;
            r_gap_cnt    <= '0;
            r_req_valid  <= 1'b0;
            r_req_addr   <= '0;
            r_sweep_done <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                r_addr[i]   <= '0;
                r_result[i] <= '0;
            end
        end else begin
            r_sweep_done <= 1'b0;

            if (i_cfg_we) begin
                r_addr[i_cfg_idx] <= i_cfg_addr;
                r_on[i_cfg_idx]   <= i_cfg_on;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_en && w_any_on) begin
                        r_ptr       <= w_first_ge;
                        r_req_valid <= 1'b1;
                        r_req_addr  <= r_addr[w_first_ge];
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.req_ready) begin
                        r_req_valid <= 1'b0;
                        r_timer     <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response on the final timeout cycle still counts as an answer.
                    if (bus.rsp_valid) begin
                        r_result[r_ptr] <= bus.rsp_data;
                        r_fresh[r_ptr]  <= 1'b1;
                        r_to[r_ptr]     <= 1'b0;
                        r_gap_cnt       <= '0;
                        r_state         <= S_GAP;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_to[r_ptr] <= 1'b1;
                        r_gap_cnt   <= '0;
                        r_state     <= S_GAP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GW'(GAP - 1)) begin
                        if (!w_any_on) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_ptr        <= w_next;
                            r_sweep_done <= (w_next <= r_ptr);
                            if (i_en) begin
                                r_req_valid <= 1'b1;
                                r_req_addr  <= r_addr[w_next];
                                r_state     <= S_ISSUE;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Config write lands last so it overrides a coincident response or timeout.
            if (i_cfg_we) begin
                r_fresh[i_cfg_idx] <= 1'b0;
                r_to[i_cfg_idx]    <= 1'b0;
            end
        end
    end

    assign bus.req_valid  = r_req_valid;
    assign bus.req_addr   = r_req_addr;
    assign o_rd_data      = r_result[i_rd_idx];
    assign o_rd_fresh     = r_fresh[i_rd_idx];
    assign o_to_flags     = r_to;
    assign o_sweep_done   = r_sweep_done;
    assign o_busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_bus_poll_scheduler.sv
// Bench for bus_poll_scheduler: directed sweeps with randomized delays/data, checked
// against a slot-table model of the poll loop.
module tb_bus_poll_scheduler;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 64;
    localparam int unsigned GP = 16;
    localparam int unsigned IW = 2;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          en       = 1'b0;
    logic          cfg_we   = 1'b0;
    logic [IW-1:0] cfg_idx  = '0;
    logic [AW-1:0] cfg_addr = '0;
    logic          cfg_on   = 1'b0;
    logic [IW-1:0] rd_idx   = '0;
    logic [DW-1:0] rd_data;
    logic          rd_fresh;
    logic [N-1:0]  to_flags;
    logic          sweep_done;
    logic          busy;

    bus_poll_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_poll_scheduler #(
        .N_SLOTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .GAP(GP)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_cfg_we     (cfg_we),
        .i_cfg_idx    (cfg_idx),
        .i_cfg_addr   (cfg_addr),
        .i_cfg_on     (cfg_on),
        .i_rd_idx     (rd_idx),
        .o_rd_data    (rd_data),
        .o_rd_fresh   (rd_fresh),
        .o_to_flags   (to_flags),
        .o_sweep_done (sweep_done),
        .o_busy       (busy),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the slot table plus the slot the poll loop is on.
    logic [AW-1:0] m_addr  [N];
    logic [DW-1:0] m_res   [N];
    bit            m_on    [N];
    bit            m_fresh [N];
    bit            m_to    [N];
    int            m_cur;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_on_from(input int start);
        for (int s = start; s < N; s++) if (m_on[s]) return s;
        for (int s = 0; s < start; s++) if (m_on[s]) return s;
        return -1;
    endfunction

    // Next slot in sweep order: lowest enabled above cur, else lowest enabled overall.
    function automatic int next_after(input int cur);
        for (int s = cur + 1; s < N; s++) if (m_on[s]) return s;
        for (int s = 0; s <= cur; s++) if (m_on[s]) return s;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_addr[i] = '0; m_res[i] = '0; m_on[i] = 0; m_fresh[i] = 0; m_to[i] = 0;
        end
        m_cur = 0;
    endtask

    task automatic cfg(input int idx, input logic [AW-1:0] a, input bit on);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_addr = a; cfg_on = on;
        tick();
        cfg_we = 1'b0;
        m_addr[idx] = a; m_on[idx] = on; m_fresh[idx] = 0; m_to[idx] = 0;
    endtask

    task automatic check_table(input string tag);
        logic [N-1:0] exp_to;
        for (int i = 0; i < N; i++) begin
            rd_idx = IW'(i);
            #1;
            chk($sformatf("%s_data%0d", tag, i), 32'(rd_data), 32'(m_res[i]));
            chk($sformatf("%s_fresh%0d", tag, i), 32'(rd_fresh), 32'(m_fresh[i]));
            exp_to[i] = m_to[i];
        end
        chk($sformatf("%s_to", tag), 32'(to_flags), 32'(exp_to));
    endtask

    task automatic wait_req(input string tag);
        int waited = 0;
        while (bus.req_valid !== 1'b1 && waited < 4) begin
            tick();
            waited++;
        end
        chk({tag, "_req_valid"}, 32'(bus.req_valid), 32'd1);
        chk({tag, "_req_addr"}, 32'(bus.req_addr), 32'(m_addr[m_cur]));
    endtask

    // One full slot transaction: request, response or timeout, then the idle gap.
    task automatic run_txn(input bit answer, input int ready_dly, input int rsp_dly,
                           input logic [DW-1:0] data, input bit drop_en, input bit clash);
        int  nxt;
        bit  wrap;
        wait_req($sformatf("txn_s%0d", m_cur));
        for (int k = 0; k < ready_dly; k++) begin
            tick();
            chk("hold_valid", 32'(bus.req_valid), 32'd1);
            chk("hold_addr", 32'(bus.req_addr), 32'(m_addr[m_cur]));
        end
        if (ready_dly > 0) chk("hold_no_to", 32'(to_flags[m_cur]), 32'(m_to[m_cur]));
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        chk("req_drop", 32'(bus.req_valid), 32'd0);
        chk("busy_wait", 32'(busy), 32'd1);
        if (drop_en) en = 1'b0;
        if (answer) begin
            repeat (rsp_dly) tick();
            bus.rsp_valid = 1'b1;
            bus.rsp_data  = data;
            if (clash) begin
                cfg_we = 1'b1; cfg_idx = IW'(m_cur); cfg_addr = m_addr[m_cur]; cfg_on = 1'b1;
            end
            tick();
            bus.rsp_valid = 1'b0;
            cfg_we        = 1'b0;
            m_res[m_cur]   = data;
            m_fresh[m_cur] = !clash;
            m_to[m_cur]    = 0;
        end else begin
            repeat (TO - 1) tick();
            chk("to_early", 32'(to_flags[m_cur]), 32'(m_to[m_cur]));
            tick();
            m_to[m_cur] = 1;
        end
        check_table($sformatf("after_s%0d", m_cur));
        repeat (GP - 1) tick();
        chk("gap_quiet", {29'd0, busy, bus.req_valid, sweep_done}, 32'b100);
        tick();
        nxt = next_after(m_cur);
        if (nxt < 0) begin
            chk("sweep_none", 32'(sweep_done), 32'd0);
            chk("busy_none", 32'(busy), 32'd0);
        end else begin
            wrap  = (nxt <= m_cur);
            m_cur = nxt;
            chk("sweep_done", 32'(sweep_done), 32'(wrap));
            chk("req_next", 32'(bus.req_valid), 32'(en));
            chk("busy_next", 32'(busy), 32'(en));
        end
    endtask

    task automatic start_sweep();
        en    = 1'b1;
        m_cur = first_on_from(m_cur);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] t1 [4];
        t1[0] = 8'h5D; t1[1] = 8'h3F; t1[2] = 8'h41; t1[3] = 8'h6C;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        model_reset();

        // Reset state, with a stray response during reset.
        bus.rsp_valid = 1'b1;
        repeat (3) tick();
        bus.rsp_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
        chk("rst_req_addr", 32'(bus.req_addr), 32'd0);
        chk("rst_sweep", 32'(sweep_done), 32'd0);
        check_table("rst");

        // Full table, fixed answers.
        cfg(0, 8'h1A, 1); cfg(1, 8'h1B, 1); cfg(2, 8'h2A, 1); cfg(3, 8'h2B, 1);
        tick();
        chk("cfg_no_start", 32'(busy), 32'd0);
        start_sweep();
        for (int s = 0; s < 4; s++) run_txn(1, $urandom_range(0, 2), $urandom_range(0, 10), t1[s], 0, 0);

        // Backpressure on slot 1, silent slot 2, then the same slot answers next sweep.
        run_txn(1, 0, $urandom_range(0, 20), 8'($urandom), 0, 0);
        run_txn(1, 20, 3, 8'($urandom), 0, 0);
        run_txn(0, 0, 0, 8'h00, 0, 0);
        run_txn(1, 0, 63, 8'($urandom), 0, 0);
        run_txn(1, 0, 5, 8'($urandom), 0, 0);
        run_txn(1, 0, 5, 8'($urandom), 0, 0);
        run_txn(1, 0, 7, 8'h41, 0, 0);
        run_txn(1, 0, 2, 8'($urandom), 0, 0);

        // Randomized sweeps, ending with EN dropped during the last wait.
        for (int t = 0; t < 8; t++) begin
            bit ans;
            ans = ($urandom_range(0, 3) != 0);
            d   = 8'($urandom);
            run_txn(ans, $urandom_range(0, 5), $urandom_range(0, 63), d, (t == 7),
                    ans && ($urandom_range(0, 3) == 0));
        end
        repeat (3) tick();
        chk("drop_idle", 32'(busy), 32'd0);

        // Only slots 1 and 3 enabled.
        cfg(0, 8'h1A, 0); cfg(2, 8'h2A, 0);
        check_table("recfg");
        start_sweep();
        for (int t = 0; t < 4; t++) run_txn(1, $urandom_range(0, 3), $urandom_range(0, 30), 8'($urandom), (t == 3), 0);
        repeat (2) tick();
        chk("alt_idle", 32'(busy), 32'd0);

        // Reset in the middle of a wait; responses during and after it are ignored.
        start_sweep();
        wait_req("rstwait");
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        en = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 8'hAA;
        tick();
        rst_n = 1'b1;
        tick();
        bus.rsp_valid = 1'b0;
        model_reset();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_valid", 32'(bus.req_valid), 32'd0);
        chk("mid_rst_req_addr", 32'(bus.req_addr), 32'd0);
        chk("mid_rst_sweep", 32'(sweep_done), 32'd0);
        check_table("mid_rst");

        // Single slot: sweep done every transaction; EN dropped during the last wait.
        cfg(0, 8'h1A, 1);
        start_sweep();
        run_txn(1, 0, $urandom_range(0, 10), 8'($urandom), 0, 0);
        run_txn(1, 1, $urandom_range(0, 10), 8'($urandom), 0, 0);
        run_txn(1, 0, 4, 8'h5D, 1, 0);
        repeat (3) tick();
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_req_valid", 32'(bus.req_valid), 32'd0);
        rd_idx = '0;
        #1;
        chk("final_data0", 32'(rd_data), 32'h5D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
